cpu_bus_serdes: RTL and testbench

Parametrised bridge between the CPU core's parallel memory port and a narrow bidirectional pin bus. One CPU access becomes a framed pin sequence: address beats, one command beat, an acknowledge wait with timeout, then data beats (driven for writes, sampled for reads). It replaces the fixed 32-bit/8-pin phase counter in the top-level pad wrapper. It adds a request/done handshake, external wait states, timeout error reporting, and configurable widths.

---
 rtl/cpu_bus_serdes.sv | 195 +++++++++++++++++++
 tb/tb_cpu_bus_serdes.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_serdes.sv
// Purpose: bridges the CPU parallel memory port onto a narrow framed pin bus
//          (address beats, command beat, ack wait with timeout, data beats).
// Latency: ADDR_W/PIN_W + DATA_W/PIN_W + 3 cycles from accept to done, plus
//          one cycle per ack-low wait state (timeout after WAIT_MAX+1 waits).
// Backpressure: one access at a time; req is ignored while busy, and the
//          target stalls the access by holding pin_ack low.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req/we/addr/wdata CPU request, latched in IDLE when req=1
//   rdata             read data, updated only by a successful read
//   busy/done/err     status: busy outside IDLE, done pulse, err = timeout
//   frame             pin-bus select, high from first address beat to last data beat
//   pin_out/pin_oe    pin drive value and output enable (all enable bits equal)
//   pin_in/pin_ack    pin receive value and target ready
module cpu_bus_serdes #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int PIN_W    = 8,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              frame,
  output logic [PIN_W-1:0]  pin_out,
  output logic [PIN_W-1:0]  pin_oe,
  input  logic [PIN_W-1:0]  pin_in,
  input  logic              pin_ack
);

  localparam int AB   = ADDR_W / PIN_W;
  localparam int DB   = DATA_W / PIN_W;
  localparam int MAXB = (AB > DB) ? AB : DB;
  localparam int BW   = $clog2(MAXB + 1);
  // WAIT_MAX=0 still needs a one-bit counter
  localparam int WW   = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CMD,
    S_WAIT,
    S_DATA,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [PIN_W-1:0]  addr_beat;
  logic [PIN_W-1:0]  wdata_beat;
  logic              drive_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      wait_q   <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      shadow_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      wait_q   <= wait_d;
      we_q     <= we_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      shadow_q <= shadow_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    wait_d   = wait_q;
    we_d     = we_q;
    err_d    = err_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    shadow_d = shadow_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_ADDR;
          beat_d  = '0;
          wait_d  = '0;
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          err_d   = 1'b0;
        end
      end
      S_ADDR: begin
        if (beat_q == BW'(AB - 1)) begin
          state_d = S_CMD;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      S_CMD: begin
        state_d = S_WAIT;
        wait_d  = '0;
      end
      S_WAIT: begin
        if (pin_ack) begin
          state_d = S_DATA;
          beat_d  = '0;
        end else if (wait_q == WW'(WAIT_MAX)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_DATA: begin
        if (!we_q) begin
          for (int k = 0; k < DB; k++) begin
            if (beat_q == BW'(k)) shadow_d[k*PIN_W +: PIN_W] = pin_in;
          end
        end
        if (beat_q == BW'(DB - 1)) begin
          state_d = S_DONE;
          beat_d  = '0;
          // shadow_d already holds the final beat merged in
          if (!we_q) rdata_d = shadow_d;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Beat selection by constant-index slices keeps the mux free of
  // variable part-selects.
  always_comb begin
    addr_beat  = '0;
    wdata_beat = '0;
    for (int k = 0; k < AB; k++) begin
      if (beat_q == BW'(k)) addr_beat = addr_q[k*PIN_W +: PIN_W];
    end
    for (int k = 0; k < DB; k++) begin
      if (beat_q == BW'(k)) wdata_beat = wdata_q[k*PIN_W +: PIN_W];
    end
  end

  always_comb begin
    pin_out = '0;
    case (state_q)
      S_ADDR:  pin_out = addr_beat;
      S_CMD:   pin_out = {{(PIN_W-1){1'b0}}, we_q};
      S_DATA:  pin_out = we_q ? wdata_beat : '0;
      default: pin_out = '0;
    endcase
  end

  assign drive_en = (state_q == S_ADDR) || (state_q == S_CMD) ||
                    ((state_q == S_DATA) && we_q);
  assign pin_oe   = {PIN_W{drive_en}};
  assign frame    = (state_q == S_ADDR) || (state_q == S_CMD) ||
                    (state_q == S_WAIT) || (state_q == S_DATA);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_DONE) && err_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_cpu_bus_serdes.sv
// Purpose: self-checking bench for cpu_bus_serdes at default widths and at
//          16/16/4; expected per-cycle pin activity is queued as stimulus is
//          planned and popped as each cycle is observed.
module tb_cpu_bus_serdes;

  localparam int WMAX = 15;

  logic        clk;
  logic        rst;
  // default-width instance
  logic        req, we, pin_ack;
  logic [31:0] addr, wdata, rdata;
  logic        busy, done, err, frame;
  logic [7:0]  pin_out, pin_oe, pin_in;
  // 16/16/4 instance
  logic        req2, we2, pin_ack2;
  logic [15:0] addr2, wdata2, rdata2;
  logic        busy2, done2, err2, frame2;
  logic [3:0]  pin_out2, pin_oe2, pin_in2;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_rdata;

  typedef struct {
    logic [7:0] po;
    logic       oe, fr, bz, dn, er;
    logic       rq, ack;
    logic [7:0] pi;
  } rec_t;
  rec_t sbq[$];

  cpu_bus_serdes dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .err(err), .frame(frame),
    .pin_out(pin_out), .pin_oe(pin_oe), .pin_in(pin_in), .pin_ack(pin_ack)
  );

  cpu_bus_serdes #(.ADDR_W(16), .DATA_W(16), .PIN_W(4), .WAIT_MAX(WMAX)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
    .rdata(rdata2), .busy(busy2), .done(done2), .err(err2), .frame(frame2),
    .pin_out(pin_out2), .pin_oe(pin_oe2), .pin_in(pin_in2), .pin_ack(pin_ack2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push(input logic [7:0] po, input logic oe, input logic fr,
                      input logic bz, input logic dn, input logic er,
                      input logic rq, input logic ack, input logic [7:0] pi);
    rec_t r;
    r.po = po; r.oe = oe; r.fr = fr; r.bz = bz; r.dn = dn; r.er = er;
    r.rq = rq; r.ack = ack; r.pi = pi;
    sbq.push_back(r);
  endtask

  // Plan the cycles from the first ADDR cycle through DONE.
  task automatic build(input int ab, input int db, input int pw, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input int nwait,
                       input bit tmo, input logic [31:0] rb, input logic hold,
                       input logic wait_req);
    logic [31:0] mask;
    mask = (32'd1 << pw) - 32'd1;
    for (int k = 0; k < ab; k++)
      push(8'((a >> (k*pw)) & mask), 1, 1, 1, 0, 0, hold, 0, 8'h00);
    push({7'b0, w}, 1, 1, 1, 0, 0, hold | wait_req, 0, 8'h00);
    if (tmo) begin
      for (int i = 0; i <= WMAX; i++) push(8'h00, 0, 1, 1, 0, 0, hold | wait_req, 0, 8'h00);
    end else begin
      for (int i = 0; i < nwait; i++) push(8'h00, 0, 1, 1, 0, 0, hold | wait_req, 0, 8'h00);
      push(8'h00, 0, 1, 1, 0, 0, hold | wait_req, 1, 8'h00);
      for (int k = 0; k < db; k++) begin
        if (w) push(8'((d >> (k*pw)) & mask), 1, 1, 1, 0, 0, hold, 0, 8'h00);
        else   push(8'h00, 0, 1, 1, 0, 0, hold, 0, 8'((rb >> (k*pw)) & mask));
      end
    end
    push(8'h00, 0, 0, 1, 1, tmo, hold, 0, 8'h00);
  endtask

  task automatic start(input logic w, input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = w; addr = a; wdata = d;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 0; we = 0; addr = '0; wdata = '0; pin_in = '0; pin_ack = 0;
    req2 = 0; we2 = 0; addr2 = '0; wdata2 = '0; pin_in2 = '0; pin_ack2 = 0;
    exp_rdata = '0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0)    begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (err !== 1'b0)     begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    total++; if (frame !== 1'b0)   begin bad++; $display("FAIL reset_frame got=%b want=0", frame); end
    total++; if (pin_oe !== 8'h00) begin bad++; $display("FAIL reset_oe got=%h want=00", pin_oe); end
    total++; if (pin_out !== 8'h00) begin bad++; $display("FAIL reset_pin_out got=%h want=00", pin_out); end
    total++; if (rdata !== 32'h0)  begin bad++; $display("FAIL reset_rdata got=%h want=0", rdata); end
    total++; if ({busy2, frame2, pin_oe2, rdata2} !== 22'h0)
      begin bad++; $display("FAIL reset_dut2 got=%h want=0", {busy2, frame2, pin_oe2, rdata2}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write(input string nm, input logic [31:0] a, input logic [31:0] d);
    rec_t r;
    int cyc;
    build(4, 4, 8, 1'b1, a, d, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    start(1'b1, a, d);
    cyc = 1;
    while (sbq.size() > 0) begin
      r = sbq.pop_front();
      total++;
      if ({pin_out, pin_oe, frame, busy, done, err} !== {r.po, {8{r.oe}}, r.fr, r.bz, r.dn, r.er}) begin
        bad++;
        $display("FAIL %s cycle %0d got po=%h oe=%h fr=%b bz=%b dn=%b er=%b want po=%h oe=%b fr=%b bz=%b dn=%b er=%b",
                 nm, cyc, pin_out, pin_oe, frame, busy, done, err, r.po, r.oe, r.fr, r.bz, r.dn, r.er);
      end
      req = r.rq; pin_ack = r.ack; pin_in = r.pi;
      @(negedge clk);
      cyc++;
    end
    req = 1'b0;
    total++; if (busy !== 1'b0 || rdata !== exp_rdata)
      begin bad++; $display("FAIL %s_after busy=%b rdata=%h want busy=0 rdata=%h", nm, busy, rdata, exp_rdata); end
  endtask

  task automatic test_read_wait(input string nm, input logic [31:0] a, input int nwait,
                                input bit tmo, input logic [31:0] rb);
    rec_t r;
    int cyc;
    // req is pulsed during CMD/WAIT; a busy bridge must ignore it
    build(4, 4, 8, 1'b0, a, 32'h0, nwait, tmo, rb, 1'b0, 1'b1);
    start(1'b0, a, 32'hFFFF_FFFF);
    cyc = 1;
    while (sbq.size() > 0) begin
      r = sbq.pop_front();
      total++;
      if ({pin_out, pin_oe, frame, busy, done, err} !== {r.po, {8{r.oe}}, r.fr, r.bz, r.dn, r.er}) begin
        bad++;
        $display("FAIL %s cycle %0d got po=%h oe=%h fr=%b bz=%b dn=%b er=%b want po=%h oe=%b fr=%b bz=%b dn=%b er=%b",
                 nm, cyc, pin_out, pin_oe, frame, busy, done, err, r.po, r.oe, r.fr, r.bz, r.dn, r.er);
      end
      if (r.dn) begin
        total++;
        if (rdata !== exp_rdata) begin
          bad++; $display("FAIL %s_rdata_at_done got=%h want=%h", nm, rdata, exp_rdata);
        end
      end
      req = r.rq; pin_ack = r.ack; pin_in = r.pi;
      @(negedge clk);
      cyc++;
    end
    req = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || rdata !== exp_rdata)
      begin bad++; $display("FAIL %s_after busy=%b rdata=%h want busy=0 rdata=%h", nm, busy, rdata, exp_rdata); end
  endtask

  task automatic test_back_to_back();
    rec_t r;
    int cyc;
    build(4, 4, 8, 1'b1, 32'h0000_0011, 32'h0000_0022, 0, 1'b0, 32'h0, 1'b1, 1'b0);
    push(8'h00, 0, 0, 0, 0, 0, 1, 0, 8'h00);   // IDLE cycle: second accept
    build(4, 4, 8, 1'b1, 32'hA0B0_C0D0, 32'h0102_0304, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    start(1'b1, 32'h0000_0011, 32'h0000_0022);
    // second request presented early; only latched at the IDLE accept
    addr = 32'hA0B0_C0D0; wdata = 32'h0102_0304;
    cyc = 1;
    while (sbq.size() > 0) begin
      r = sbq.pop_front();
      total++;
      if ({pin_out, pin_oe, frame, busy, done, err} !== {r.po, {8{r.oe}}, r.fr, r.bz, r.dn, r.er}) begin
        bad++;
        $display("FAIL b2b cycle %0d got po=%h oe=%h fr=%b bz=%b dn=%b er=%b want po=%h oe=%b fr=%b bz=%b dn=%b er=%b",
                 cyc, pin_out, pin_oe, frame, busy, done, err, r.po, r.oe, r.fr, r.bz, r.dn, r.er);
      end
      req = r.rq; pin_ack = r.ack; pin_in = r.pi;
      @(negedge clk);
      cyc++;
    end
    req = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_after busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    rec_t r;
    build(4, 4, 8, 1'b1, 32'h5566_7788, 32'h99AA_BBCC, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    start(1'b1, 32'h5566_7788, 32'h99AA_BBCC);
    // run 4 ADDR + CMD + WAIT + 2 DATA cycles, land inside DATA beat 2
    for (int i = 0; i < 8; i++) begin
      r = sbq.pop_front();
      req = r.rq; pin_ack = r.ack; pin_in = r.pi;
      @(negedge clk);
    end
    total++; if (pin_out !== 8'hAA || pin_oe !== 8'hFF)
      begin bad++; $display("FAIL rstmid_pre got po=%h oe=%h want po=aa oe=ff", pin_out, pin_oe); end
    #1 rst = 1'b1;
    #1;
    total++; if ({pin_oe, frame, busy, done} !== 11'h0)
      begin bad++; $display("FAIL rstmid_immediate got oe=%h fr=%b bz=%b dn=%b want all 0", pin_oe, frame, busy, done); end
    sbq.delete();
    exp_rdata = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (done !== 1'b0 || busy !== 1'b0)
        begin bad++; $display("FAIL rstmid_no_done i=%0d got dn=%b bz=%b want 0 0", i, done, busy); end
    end
    test_write("rstmid_recover", 32'h1357_9BDF, 32'h2468_ACE0);
  endtask

  task automatic test_small_params();
    rec_t r;
    int cyc;
    build(4, 4, 4, 1'b1, 32'h0000_BEEF, 32'h0000_1234, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    build(4, 4, 4, 1'b0, 32'h0000_0F0F, 32'h0, 1, 1'b0, 32'h0000_9C3E, 1'b0, 1'b0);
    req2 = 1'b1; we2 = 1'b1; addr2 = 16'hBEEF; wdata2 = 16'h1234;
    @(negedge clk);
    cyc = 1;
    while (sbq.size() > 0) begin
      r = sbq.pop_front();
      total++;
      if ({pin_out2, pin_oe2, frame2, busy2, done2, err2} !== {r.po[3:0], {4{r.oe}}, r.fr, r.bz, r.dn, r.er}) begin
        bad++;
        $display("FAIL small cycle %0d got po=%h oe=%h fr=%b bz=%b dn=%b er=%b want po=%h oe=%b fr=%b bz=%b dn=%b er=%b",
                 cyc, pin_out2, pin_oe2, frame2, busy2, done2, err2, r.po[3:0], r.oe, r.fr, r.bz, r.dn, r.er);
      end
      req2 = r.rq; pin_ack2 = r.ack; pin_in2 = r.pi[3:0];
      @(negedge clk);
      cyc++;
      // after the write's DONE, this is the IDLE cycle: launch the read
      if (cyc == 12) begin
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL small_idle busy=%b want 0", busy2); end
        req2 = 1'b1; we2 = 1'b0; addr2 = 16'h0F0F;
        @(negedge clk);
      end
    end
    req2 = 1'b0;
    total++; if (rdata2 !== 16'h9C3E)
      begin bad++; $display("FAIL small_rdata got=%h want=9c3e", rdata2); end
  endtask

  initial begin
    test_reset();
    test_write("write", 32'h1234_5678, 32'hCAFE_F00D);
    exp_rdata = 32'hD4C3_B2A1;
    test_read_wait("read3", 32'h0000_0100, 3, 1'b0, 32'hD4C3_B2A1);
    test_read_wait("timeout", 32'h0000_0200, 0, 1'b1, 32'h0);
    exp_rdata = 32'h0F1E_2D3C;
    test_read_wait("read0", 32'h0000_0300, 0, 1'b0, 32'h0F1E_2D3C);
    test_back_to_back();
    test_reset_mid();
    test_small_params();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
